// File: rtl/dop_dec.sv
// DoP (DSD over PCM) decoder: validates DoP markers on incoming stereo PCM
// frames, locks onto a marker stream, buffers DSD payload words and paces
// them out to a DSD serializer, one word pair every 16 bclk.
module dop_dec #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned PREFILL  = 2
) (
    input  logic        bclk,
    input  logic        rst,
    input  logic        pcm_valid,
    input  logic [23:0] pcm_ldata,
    input  logic [23:0] pcm_rdata,
    output logic        valid_o,
    output logic [15:0] ldata_o,
    output logic [15:0] rdata_o,
    output logic        dop_lock,
    output logic        err_marker,
    output logic        err_ovf,
    output logic        err_udf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam logic [15:0] DSD_SILENCE = 16'h6969;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKING,
        ST_LOCKED
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_gcnt;
    logic [7:0]      r_last_marker;
    logic            r_dop_lock;
    logic            r_err_marker;

    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            r_running;
    logic [3:0]      r_slot;
    logic            r_valid;
    logic [15:0]     r_ldata;
    logic [15:0]     r_rdata;
    logic            r_err_ovf;
    logic            r_err_udf;

    logic [7:0]      w_lmark;
    logic [7:0]      w_rmark;
    logic            w_marker_ok;
    logic            w_unlock;
    logic            w_wr_req;
    logic            w_full;
    logic            w_empty;
    logic            w_strobe;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf;
    logic            w_start;
    logic [GW-1:0]   w_gcnt_inc;

    // Marker qualification and FIFO / pacing control decisions for this edge
    always_comb begin
        w_lmark     = pcm_ldata[23:16];
        w_rmark     = pcm_rdata[23:16];
        w_marker_ok = (w_lmark == w_rmark)
                   && ((w_lmark == 8'h05) || (w_lmark == 8'hFA))
                   && ((r_state == ST_UNLOCKED) || (w_lmark != r_last_marker));
        w_unlock    = pcm_valid && (r_state == ST_LOCKED) && !w_marker_ok;
        w_wr_req    = pcm_valid && (r_state == ST_LOCKED) && w_marker_ok;
        w_full      = (r_count == CW'(DEPTH));
        w_empty     = (r_count == CW'(0));
        // strobe fires as the slot counter wraps into slot 0
        w_strobe    = r_running && (r_slot == 4'd15) && !w_unlock;
        w_pop       = w_strobe && !w_empty;
        w_push      = w_wr_req && (!w_full || w_pop);
        w_ovf       = w_wr_req && w_full && !w_pop;
        w_start     = (r_state == ST_LOCKED) && !r_running && !w_unlock
                   && (r_count >= CW'(PREFILL));
        w_gcnt_inc  = r_gcnt + GW'(1);
    end

    // Marker lock state machine, evaluated only on frame strobes
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_UNLOCKED;
            r_gcnt        <= '0;
            r_last_marker <= 8'h00;
            r_dop_lock    <= 1'b0;
            r_err_marker  <= 1'b0;
        end else begin
            r_err_marker <= 1'b0;
            if (pcm_valid) begin
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_marker_ok) begin
                            r_last_marker <= w_lmark;
                            r_gcnt        <= GW'(1);
                            if (LOCK_CNT <= 1) begin
                                r_state    <= ST_LOCKED;
                                r_dop_lock <= 1'b1;
                            end else begin
                                r_state <= ST_LOCKING;
                            end
                        end
                    end
                    ST_LOCKING: begin
                        if (w_marker_ok) begin
                            r_last_marker <= w_lmark;
                            r_gcnt        <= w_gcnt_inc;
                            if (w_gcnt_inc >= GW'(LOCK_CNT)) begin
                                r_state    <= ST_LOCKED;
                                r_dop_lock <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_UNLOCKED;
                            r_gcnt  <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_marker_ok) begin
                            r_last_marker <= w_lmark;
                        end else begin
                            r_state      <= ST_UNLOCKED;
                            r_gcnt       <= '0;
                            r_dop_lock   <= 1'b0;
                            r_err_marker <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= ST_UNLOCKED;
                        r_gcnt     <= '0;
                        r_dop_lock <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Payload storage; contents need no reset since the count gates reads
    always_ff @(posedge bclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {pcm_ldata[15:0], pcm_rdata[15:0]};
        end
    end

    // FIFO pointers and occupancy; an unlock flushes everything
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_unlock) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output pacing: 16-slot cadence, pop or silence on each strobe
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            r_running <= 1'b0;
            r_slot    <= 4'd0;
            r_valid   <= 1'b0;
            r_ldata   <= 16'h0000;
            r_rdata   <= 16'h0000;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_err_udf <= 1'b0;
            r_err_ovf <= w_ovf;
            if (w_unlock) begin
                r_running <= 1'b0;
                r_slot    <= 4'd0;
            end else if (w_start) begin
                r_running <= 1'b1;
                r_slot    <= 4'd0;
            end else if (r_running) begin
                r_slot <= r_slot + 4'd1;
                if (w_strobe) begin
                    r_valid <= 1'b1;
                    if (w_pop) begin
                        r_ldata <= r_mem[r_rptr][31:16];
                        r_rdata <= r_mem[r_rptr][15:0];
                    end else begin
                        r_ldata   <= DSD_SILENCE;
                        r_rdata   <= DSD_SILENCE;
                        r_err_udf <= 1'b1;
                    end
                end
            end
        end
    end

    assign valid_o    = r_valid;
    assign ldata_o    = r_ldata;
    assign rdata_o    = r_rdata;
    assign dop_lock   = r_dop_lock;
    assign err_marker = r_err_marker;
    assign err_ovf    = r_err_ovf;
    assign err_udf    = r_err_udf;

endmodule
